level_judge: RTL and testbench
==============================

Name: level_judge

Overview:
- Produces the `gameover` / `gamewin` level signals consumed by the top-level game-flow controller.
- Consumes that controller's one-cycle `revive` pulse, which restarts judging.
- Sits between the character/collision logic and the game-flow FSM.
- Qualifies hazard contact and door arrival over consecutive frames, counts collected gems, and latches the final verdict until the next revive.

Parameters:
- GRACE_FRAMES, 4: frame ticks after revive during which hazards are ignored.
- HAZARD_FRAMES, 2: consecutive hazard-sampled frame ticks needed to confirm death (≥1).
- DOOR_FRAMES, 30: consecutive frame ticks with both players at their doors needed to confirm a win (≥1).
- GEMS_REQUIRED, 3: minimum gem count for a win to be accepted.
- GEM_W, 4: width of the gem counter.

Ports:
- Clk  input  1  system clock
- Reset  input  1  synchronous, active-high reset
- frame_tick  input  1  one-Clk pulse per video frame (vsync-derived)
- revive  input  1  one-Clk pulse from the game-flow controller: restart the level
- fire_hazard  input  1  fireboy overlaps water or poison (level)
- ice_hazard  input  1  icegirl overlaps fire or poison (level)
- fire_at_door  input  1  fireboy inside the red door region (level)
- ice_at_door  input  1  icegirl inside the blue door region (level)
- gem_pulse  input  1  one-Clk pulse per gem collected (either player)
- gameover  output  1  registered; high in OVER
- gamewin  output  1  registered; high in WIN
- gem_count  output  GEM_W  gems collected since last revive, saturating
- playing  output  1  high in PLAY (enables player motion)

Behaviour:
- Reset values:
  - state = IDLE.
  - gameover, gamewin, playing = 0.
  - gem_count = 0.
  - All internal counters = 0.
- States: IDLE, GRACE, PLAY, OVER, WIN.
- revive has top priority over all transitions in every state:
  - Next state = GRACE.
  - grace_cnt, haz_cnt, door_cnt, gem_count cleared.
- IDLE:
  - Waits for revive; all other inputs ignored.
  - A revive that arrives before any game start is still honoured.
- GRACE:
  - Each frame_tick increments grace_cnt.
  - On the tick where grace_cnt == GRACE_FRAMES-1, the next state is PLAY.
  - Hazards and doors are ignored.
  - Gems are counted.
- PLAY, per frame_tick (inputs sampled only on frame_tick cycles):
  - Hazard counter:
    - If (fire_hazard | ice_hazard), haz_cnt += 1, otherwise haz_cnt = 0.
    - Death is confirmed when the sampled hazard is high and haz_cnt == HAZARD_FRAMES-1.
  - Door counter:
    - If (fire_at_door & ice_at_door), door_cnt += 1, otherwise door_cnt = 0.
    - Win is confirmed when both are at their doors, door_cnt == DOOR_FRAMES-1, and gem_count ≥ GEMS_REQUIRED.
    - If the door condition persists without enough gems, door_cnt saturates at DOOR_FRAMES-1. The win fires on the first tick where the gem requirement becomes met while both players are still at their doors.
  - Death confirm → OVER.
  - Win confirm (no death) → WIN.
  - Both confirm on the same tick → OVER (death has priority).
- OVER / WIN:
  - Absorbing until revive.
  - Gem pulses are ignored.
  - Counters are frozen.
- Output timing:
  - Outputs are decoded from the registered state.
  - gameover / gamewin rise exactly one Clk after the confirming frame_tick cycle.
  - playing falls at the same time.
- gem_count:
  - Increments on gem_pulse in GRACE or PLAY.
  - Saturates at 2^GEM_W-1.
  - A gem_pulse in the same cycle as revive is dropped (revive clears the count).
- Tick handling:
  - frame_tick and gem_pulse in the same cycle: the gem counts first. The win check on that tick uses the incremented value.
  - frame_tick held high for multiple cycles: each high cycle is treated as a separate tick. Upstream guarantees single-cycle pulses.
- Reset mid-game: returns to IDLE with all outputs 0 on the next edge regardless of state.

Test Plan:
- Reset, then revive, then 4 frame_ticks → playing=0 for 4 ticks, playing=1 one Clk after the 4th tick.
- In PLAY, fire_hazard high for 2 consecutive ticks → gameover=1 one Clk after the 2nd tick; playing=0; gamewin stays 0.
- In PLAY, hazard high on ticks 1,3,5 (low on ticks 2,4) → no gameover (counter resets).
- Hazard during GRACE for all 4 ticks → no gameover.
- 3 gem pulses, then both at doors for 30 ticks → gamewin=1 one Clk after the 30th tick; gem_count=3.
- Only 2 gems, both at doors for 40 ticks, then a gem_pulse coincident with tick 41 → gamewin=1 one Clk after tick 41.
- On one tick, completing both the hazard count and the door count → gameover=1, gamewin=0.
- In OVER, revive → gameover=0 next Clk, state GRACE, gem_count=0.
- With GEM_W=4, 20 gem_pulses → gem_count=15.
- Reset asserted while in WIN → gamewin=0 and playing=0 next Clk.

Source files
------------

// File: rtl/level_judge.sv
// level_judge
//   Decides when a level is lost or won. It works on per-frame samples from
//   the character/collision logic and reports the result to the game-flow
//   controller. After a revive pulse, hazards are ignored for a grace period.
//   Death and door arrival must then hold for several consecutive frame ticks
//   before they count. The verdict stays latched until the next revive.
//
//   State table (state | meaning):
//     IDLE  | after reset, waiting for the first revive
//     GRACE | level restarted, hazards/doors ignored, gems counted
//     PLAY  | normal judging, players may move
//     OVER  | death confirmed, frozen until revive
//     WIN   | both at doors with enough gems, frozen until revive
//
// Ports:
//   Clk, Reset     system clock, synchronous active-high reset
//   frame_tick     one-Clk pulse per video frame
//   revive         one-Clk restart pulse, top priority in every state
//   fire_hazard    fireboy touching water/poison (level)
//   ice_hazard     icegirl touching fire/poison (level)
//   fire_at_door   fireboy inside red door (level)
//   ice_at_door    icegirl inside blue door (level)
//   gem_pulse      one-Clk pulse per collected gem
//   gameover       high in OVER (registered)
//   gamewin        high in WIN (registered)
//   gem_count      gems since last revive, saturating
//   playing        high in PLAY (registered)
module level_judge #(
  parameter int GRACE_FRAMES  = 4,
  parameter int HAZARD_FRAMES = 2,
  parameter int DOOR_FRAMES   = 30,
  parameter int GEMS_REQUIRED = 3,
  parameter int GEM_W         = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             frame_tick,
  input  logic             revive,
  input  logic             fire_hazard,
  input  logic             ice_hazard,
  input  logic             fire_at_door,
  input  logic             ice_at_door,
  input  logic             gem_pulse,
  output logic             gameover,
  output logic             gamewin,
  output logic [GEM_W-1:0] gem_count,
  output logic             playing
);

  localparam int GW = (GRACE_FRAMES  > 1) ? $clog2(GRACE_FRAMES)  : 1;
  localparam int HW = (HAZARD_FRAMES > 1) ? $clog2(HAZARD_FRAMES) : 1;
  localparam int DW = (DOOR_FRAMES   > 1) ? $clog2(DOOR_FRAMES)   : 1;

  localparam logic [GW-1:0] GRACE_LAST = GW'(GRACE_FRAMES - 1);
  localparam logic [HW-1:0] HAZ_LAST   = HW'(HAZARD_FRAMES - 1);
  localparam logic [DW-1:0] DOOR_LAST  = DW'(DOOR_FRAMES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRACE = 3'd1,
    PLAY  = 3'd2,
    OVER  = 3'd3,
    WIN   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [GW-1:0]    grace_cnt_q, grace_cnt_d;
  logic [HW-1:0]    haz_cnt_q, haz_cnt_d;
  logic [DW-1:0]    door_cnt_q, door_cnt_d;
  logic [GEM_W-1:0] gem_cnt_q, gem_cnt_d;
  logic [GEM_W-1:0] gem_next;
  logic             gameover_q, gameover_d;
  logic             gamewin_q, gamewin_d;
  logic             playing_q, playing_d;
  logic             hazard, at_doors, death, win;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      grace_cnt_q <= '0;
      haz_cnt_q   <= '0;
      door_cnt_q  <= '0;
      gem_cnt_q   <= '0;
      gameover_q  <= 1'b0;
      gamewin_q   <= 1'b0;
      playing_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grace_cnt_q <= grace_cnt_d;
      haz_cnt_q   <= haz_cnt_d;
      door_cnt_q  <= door_cnt_d;
      gem_cnt_q   <= gem_cnt_d;
      gameover_q  <= gameover_d;
      gamewin_q   <= gamewin_d;
      playing_q   <= playing_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grace_cnt_d = grace_cnt_q;
    haz_cnt_d   = haz_cnt_q;
    door_cnt_d  = door_cnt_q;
    gem_cnt_d   = gem_cnt_q;
    hazard      = fire_hazard | ice_hazard;
    at_doors    = fire_at_door & ice_at_door;
    death       = 1'b0;
    win         = 1'b0;

    // Gem from this cycle is included so a win check on the same tick sees it.
    gem_next = (gem_pulse && (gem_cnt_q != '1)) ? gem_cnt_q + GEM_W'(1) : gem_cnt_q;

    unique case (state_q)
      IDLE: ;
      GRACE: begin
        gem_cnt_d = gem_next;
        if (frame_tick) begin
          if (grace_cnt_q == GRACE_LAST) state_d = PLAY;
          else                           grace_cnt_d = grace_cnt_q + GW'(1);
        end
      end
      PLAY: begin
        gem_cnt_d = gem_next;
        if (frame_tick) begin
          death = hazard && (haz_cnt_q == HAZ_LAST);
          win   = at_doors && (door_cnt_q == DOOR_LAST) &&
                  (32'(gem_next) >= GEMS_REQUIRED);
          if (!hazard)                     haz_cnt_d = '0;
          else if (haz_cnt_q != HAZ_LAST)  haz_cnt_d = haz_cnt_q + HW'(1);
          // Door count holds at its last value while waiting for gems.
          if (!at_doors)                   door_cnt_d = '0;
          else if (door_cnt_q != DOOR_LAST) door_cnt_d = door_cnt_q + DW'(1);
          if (death)    state_d = OVER;
          else if (win) state_d = WIN;
        end
      end
      OVER, WIN: ;
      default: state_d = IDLE;
    endcase

    if (revive) begin
      state_d     = GRACE;
      grace_cnt_d = '0;
      haz_cnt_d   = '0;
      door_cnt_d  = '0;
      gem_cnt_d   = '0;
    end

    gameover_d = (state_d == OVER);
    gamewin_d  = (state_d == WIN);
    playing_d  = (state_d == PLAY);
  end

  assign gameover  = gameover_q;
  assign gamewin   = gamewin_q;
  assign playing   = playing_q;
  assign gem_count = gem_cnt_q;

endmodule

// File: tb/tb_level_judge.sv
// tb_level_judge
//   Directed bench for level_judge with default parameters. Inputs change on
//   the falling edge and outputs are sampled on the falling edge, so each
//   pulse task spans exactly one rising edge.
module tb_level_judge;

  logic       Clk, Reset;
  logic       frame_tick, revive, fire_hazard, ice_hazard;
  logic       fire_at_door, ice_at_door, gem_pulse;
  logic       gameover, gamewin, playing;
  logic [3:0] gem_count;

  int n_total = 0;
  int n_pass  = 0;

  level_judge dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_tick   (frame_tick),
    .revive       (revive),
    .fire_hazard  (fire_hazard),
    .ice_hazard   (ice_hazard),
    .fire_at_door (fire_at_door),
    .ice_at_door  (ice_at_door),
    .gem_pulse    (gem_pulse),
    .gameover     (gameover),
    .gamewin      (gamewin),
    .gem_count    (gem_count),
    .playing      (playing)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
  endtask

  task automatic do_revive();
    revive = 1'b1;
    @(negedge Clk);
    revive = 1'b0;
  endtask

  task automatic gem();
    gem_pulse = 1'b1;
    @(negedge Clk);
    gem_pulse = 1'b0;
  endtask

  task automatic outs(input string tag, input logic go, input logic gw, input logic pl);
    chk({tag, ".gameover"}, 32'(gameover), 32'(go));
    chk({tag, ".gamewin"},  32'(gamewin),  32'(gw));
    chk({tag, ".playing"},  32'(playing),  32'(pl));
  endtask

  initial begin
    Reset = 1'b1; frame_tick = 1'b0; revive = 1'b0; fire_hazard = 1'b0;
    ice_hazard = 1'b0; fire_at_door = 1'b0; ice_at_door = 1'b0; gem_pulse = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    outs("reset", 1'b0, 1'b0, 1'b0);
    chk("reset.gem_count", 32'(gem_count), 32'd0);

    // IDLE ignores gems and ticks
    gem(); tick();
    chk("idle.gem_count", 32'(gem_count), 32'd0);
    chk("idle.playing", 32'(playing), 32'd0);

    // Revive, grace with hazard held high the whole time
    do_revive();
    fire_hazard = 1'b1;
    repeat (3) tick();
    outs("grace3", 1'b0, 1'b0, 1'b0);
    tick();
    fire_hazard = 1'b0;
    outs("grace4", 1'b0, 1'b0, 1'b1);

    // Alternating hazard never confirms death; two gems collected meanwhile
    gem(); gem();
    for (int i = 1; i <= 5; i++) begin
      fire_hazard = (i % 2 == 1);
      tick();
    end
    fire_hazard = 1'b0;
    outs("alt", 1'b0, 1'b0, 1'b1);
    tick();

    // Two consecutive hazard ticks confirm death
    ice_hazard = 1'b1;
    tick();
    outs("haz1", 1'b0, 1'b0, 1'b1);
    tick();
    ice_hazard = 1'b0;
    outs("haz2", 1'b1, 1'b0, 1'b0);

    // OVER is absorbing and ignores gems
    gem(); tick();
    chk("over.gem_count", 32'(gem_count), 32'd2);
    chk("over.gameover", 32'(gameover), 32'd1);

    // Revive from OVER; coincident gem is dropped
    gem_pulse = 1'b1;
    do_revive();
    gem_pulse = 1'b0;
    outs("revive_over", 1'b0, 1'b0, 1'b0);
    chk("revive_over.gem_count", 32'(gem_count), 32'd0);
    repeat (4) tick();
    chk("regrace.playing", 32'(playing), 32'd1);

    // Win after 3 gems and 30 door ticks
    repeat (3) gem();
    fire_at_door = 1'b1; ice_at_door = 1'b1;
    repeat (29) tick();
    outs("door29", 1'b0, 1'b0, 1'b1);
    tick();
    outs("door30", 1'b0, 1'b1, 1'b0);
    chk("door30.gem_count", 32'(gem_count), 32'd3);
    fire_at_door = 1'b0; ice_at_door = 1'b0;

    // Reset while in WIN
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    outs("reset_win", 1'b0, 1'b0, 1'b0);
    chk("reset_win.gem_count", 32'(gem_count), 32'd0);

    // Only 2 gems: door count saturates, win comes with the 3rd gem on tick 41
    do_revive();
    repeat (4) tick();
    gem(); gem();
    fire_at_door = 1'b1; ice_at_door = 1'b1;
    repeat (40) tick();
    outs("door40", 1'b0, 1'b0, 1'b1);
    gem_pulse = 1'b1;
    tick();
    gem_pulse = 1'b0;
    outs("door41", 1'b0, 1'b1, 1'b0);
    chk("door41.gem_count", 32'(gem_count), 32'd3);
    fire_at_door = 1'b0; ice_at_door = 1'b0;

    // Death and win confirmed on the same tick: death wins
    do_revive();
    repeat (4) tick();
    repeat (3) gem();
    fire_at_door = 1'b1; ice_at_door = 1'b1;
    repeat (28) tick();
    fire_hazard = 1'b1;
    tick();
    outs("both29", 1'b0, 1'b0, 1'b1);
    tick();
    outs("both30", 1'b1, 1'b0, 1'b0);
    fire_hazard = 1'b0; fire_at_door = 1'b0; ice_at_door = 1'b0;

    // Gem counter saturation, gems counted in GRACE and PLAY
    do_revive();
    repeat (2) gem();
    chk("grace.gem_count", 32'(gem_count), 32'd2);
    repeat (4) tick();
    repeat (18) gem();
    chk("sat.gem_count", 32'(gem_count), 32'd15);
    chk("sat.playing", 32'(playing), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
